// File: rtl/enc_gray_pkg.sv
// ---------------------------------------------------------------------------
// enc_gray_pkg
// Shared types and helpers for the pipelined binary/Gray codec.
//   mode_e       : per-word conversion direction (encode / decode)
//   stage_pay_t  : payload carried by every pipeline stage (mode, data, carry)
//   chunk_lo/hi  : bit range of the decode chunk resolved by stage k (1-based)
//   bin2gray     : binary to reflected Gray conversion
// Payload data is held at MAX_W bits; bits at and above WIDTH stay zero.
// ---------------------------------------------------------------------------
package enc_gray_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [MAX_W-1:0] data;
    logic             carry;
  } stage_pay_t;

  function automatic int chunk_size(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Low bit of chunk k; clamps at 0 so a short final chunk is well formed.
  function automatic int chunk_lo(input int k, input int width, input int stages);
    int lo;
    lo = width - k * chunk_size(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

  // High bit of chunk k; may fall below chunk_lo, meaning the chunk is empty.
  function automatic int chunk_hi(input int k, input int width, input int stages);
    return width - 1 - (k - 1) * chunk_size(width, stages);
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/enc_gray_codec_pipe_stage.sv
// ---------------------------------------------------------------------------
// enc_gray_stage
// One pipeline register of the Gray codec with its advance logic.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_valid     : upstream word valid
//   i_pay       : upstream payload (mode, partially converted data, carry)
//   i_dn_adv    : downstream stage (or output port) will advance this cycle
//   o_adv       : this stage advances (empty or downstream advancing)
//   o_valid     : registered valid
//   o_pay       : registered payload
// Stage 1 performs the whole encode; every stage resolves its own decode
// chunk, MSB first, seeded by the carry from the stage above.
// ---------------------------------------------------------------------------
module enc_gray_stage
  import enc_gray_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2,
  parameter int K      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  stage_pay_t i_pay,
  input  logic       i_dn_adv,
  output logic       o_adv,
  output logic       o_valid,
  output stage_pay_t o_pay
);

  localparam int          LO   = chunk_lo(K, WIDTH, STAGES);
  localparam int          HI   = chunk_hi(K, WIDTH, STAGES);
  localparam int unsigned CLEN = (HI >= LO) ? int'(HI - LO + 1) : 0;

  logic       r_valid;
  stage_pay_t r_pay;
  stage_pay_t w_nxt;

  // Empty stages always accept, so bubbles collapse upstream of a stall.
  assign o_adv   = !r_valid || i_dn_adv;
  assign o_valid = r_valid;
  assign o_pay   = r_pay;

  always_comb begin : p_convert
    logic             v_c;
    logic [IDX_W-1:0] v_b;
    w_nxt = i_pay;
    v_c   = i_pay.carry;
    v_b   = '0;
    if (i_pay.mode == MODE_ENC) begin
      if (K == 1) begin
        w_nxt.data = bin2gray(i_pay.data);
      end
    end else begin
      // Prefix XOR over this stage's chunk; v_c always holds bin[v_b+1].
      for (int unsigned n = 0; n < CLEN; n++) begin
        v_b             = IDX_W'(HI - int'(n));
        v_c             = i_pay.data[v_b] ^ v_c;
        w_nxt.data[v_b] = v_c;
      end
      w_nxt.carry = v_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pay   <= '0;
    end else if (o_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_pay <= w_nxt;
      end
    end
  end

endmodule

// File: rtl/enc_gray_codec_pipe.sv
// ---------------------------------------------------------------------------
// enc_gray_codec_pipe
// Pipelined binary<->Gray converter with per-word direction, valid/ready on
// both sides and a saturating count of completed output transfers.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready has no path from in_valid)
//   in_mode, in_data      : 0 = encode, 1 = decode; word to convert
//   out_valid / out_ready : output handshake
//   out_mode, out_data    : direction used and converted word (flop outputs)
//   xfer_count            : output transfers, saturating at all-ones
//   clr_count             : synchronous clear of xfer_count (wins over a count)
// Latency is STAGES cycles; one word per cycle sustained.
// ---------------------------------------------------------------------------
module enc_gray_codec_pipe
  import enc_gray_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count,
  input  logic             clr_count
);

  logic             w_valid [1:STAGES];
  stage_pay_t       w_pay   [1:STAGES];
  stage_pay_t       w_in_pay;
  logic             w_last_adv;
  logic             w_out_xfer;
  logic [CNT_W-1:0] r_count;

  always_comb begin
    w_in_pay       = '0;
    w_in_pay.mode  = mode_e'(in_mode);
    w_in_pay.data  = MAX_W'(in_data);
    w_in_pay.carry = 1'b0;
  end

  assign w_last_adv = !w_valid[STAGES] || out_ready;
  assign w_out_xfer = w_valid[STAGES] && out_ready;

  // Advance wires live per generate block so the ready chain is not one
  // self-referencing vector.
  for (genvar k = 1; k <= STAGES; k++) begin : g_st
    logic       w_up_valid;
    stage_pay_t w_up_pay;
    logic       w_dn_adv;
    logic       w_adv;

    if (k == 1) begin : g_first
      assign w_up_valid = in_valid;
      assign w_up_pay   = w_in_pay;
    end else begin : g_mid
      assign w_up_valid = w_valid[k-1];
      assign w_up_pay   = w_pay[k-1];
    end

    if (k == STAGES) begin : g_last
      assign w_dn_adv = w_last_adv;
    end else begin : g_inner
      assign w_dn_adv = g_st[k+1].w_adv;
    end

    enc_gray_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .K      (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_valid  (w_up_valid),
      .i_pay    (w_up_pay),
      .i_dn_adv (w_dn_adv),
      .o_adv    (w_adv),
      .o_valid  (w_valid[k]),
      .o_pay    (w_pay[k])
    );
  end

  assign in_ready   = g_st[1].w_adv;
  assign out_valid  = w_valid[STAGES];
  assign out_mode   = w_pay[STAGES].mode;
  assign out_data   = WIDTH'(w_pay[STAGES].data);
  assign xfer_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= '0;
    end else if (w_out_xfer && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_enc_gray_codec_pipe.sv
module tb_enc_gray_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Unit A: WIDTH=10, STAGES=2, CNT_W=16
  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode, a_clr;
  logic [9:0]  a_in_data, a_out_data;
  logic [15:0] a_cnt;
  // Unit B: WIDTH=33, STAGES=4, CNT_W=4
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_clr;
  logic [32:0] b_in_data, b_out_data;
  logic [3:0]  b_cnt;

  enc_gray_codec_pipe #(.WIDTH(10), .STAGES(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data),
    .xfer_count(a_cnt), .clr_count(a_clr));

  enc_gray_codec_pipe #(.WIDTH(33), .STAGES(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data),
    .xfer_count(b_cnt), .clr_count(b_clr));

  typedef struct {
    logic [63:0] d;
    logic        m;
    int          c;
  } exp_t;

  exp_t        sbq   [2][$];
  logic [63:0] cap_e [2][$];
  logic [63:0] orig  [2][$];
  int  W    [2] = '{10, 33};
  int  S    [2] = '{2, 4};
  int  CMAX [2] = '{65535, 15};
  int  cnt_m [2];
  bit  lat_en [2];
  bit  cap_en [2];
  bit  stall_p [2];
  logic [63:0] prev_d [2];
  logic        prev_m [2];
  bit  bp_a;
  int  cyc;
  int  n_chk, n_pass;

  function automatic logic [63:0] msk(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] x, input int w);
    return (x ^ (x >> 1)) & msk(w);
  endfunction

  // bin[i] is the XOR of all Gray bits at or above i.
  function automatic logic [63:0] m_dec(input logic [63:0] g, input int w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r = r ^ (g >> k);
    return r & msk(w);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mon(input int u, input logic iv, input logic ir, input logic im,
                     input logic [63:0] id, input logic ov, input logic orr,
                     input logic om, input logic [63:0] od, input logic clr, input int cnt);
    exp_t e;
    exp_t ne;
    logic exp_ir;
    if (!rst_n) begin
      chk($sformatf("rst_out_valid%0d", u), 64'(ov), 64'd0);
      chk($sformatf("rst_count%0d", u), 64'(cnt), 64'd0);
      sbq[u].delete();
      cap_e[u].delete();
      orig[u].delete();
      cnt_m[u]   = 0;
      stall_p[u] = 1'b0;
      return;
    end
    chk($sformatf("count%0d", u), 64'(cnt), 64'(cnt_m[u]));
    exp_ir = !((sbq[u].size() == S[u]) && !orr);
    chk($sformatf("in_ready%0d", u), 64'(ir), 64'(exp_ir));
    if (stall_p[u]) begin
      chk($sformatf("stall_valid%0d", u), 64'(ov), 64'd1);
      chk($sformatf("stall_data%0d", u), od, prev_d[u]);
      chk($sformatf("stall_mode%0d", u), 64'(om), 64'(prev_m[u]));
    end
    if (ov) begin
      if (sbq[u].size() == 0) begin
        chk($sformatf("spurious_out%0d", u), 64'(ov), 64'd0);
      end else if (orr) begin
        e = sbq[u].pop_front();
        chk($sformatf("out_data%0d", u), od, e.d);
        chk($sformatf("out_mode%0d", u), 64'(om), 64'(e.m));
        if (lat_en[u]) chk($sformatf("latency%0d", u), 64'(cyc - e.c), 64'(S[u]));
        if (cap_en[u]) begin
          if (!om) cap_e[u].push_back(od);
          else if (orig[u].size() > 0) chk($sformatf("roundtrip%0d", u), od, orig[u].pop_front());
          else chk($sformatf("roundtrip_extra%0d", u), 64'd1, 64'd0);
        end
        if (cnt_m[u] < CMAX[u]) cnt_m[u]++;
      end
    end
    if (clr) cnt_m[u] = 0;
    stall_p[u] = ov && !orr;
    prev_d[u]  = od;
    prev_m[u]  = om;
    if (iv && ir) begin
      ne.d = im ? m_dec(id, W[u]) : m_enc(id, W[u]);
      ne.m = im;
      ne.c = cyc;
      sbq[u].push_back(ne);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, a_in_valid, a_in_ready, a_in_mode, 64'(a_in_data), a_out_valid, a_out_ready,
        a_out_mode, 64'(a_out_data), a_clr, int'(a_cnt));
    mon(1, b_in_valid, b_in_ready, b_in_mode, 64'(b_in_data), b_out_valid, b_out_ready,
        b_out_mode, 64'(b_out_data), b_clr, int'(b_cnt));
  end

  task automatic send_a(input logic m, input logic [9:0] d);
    bit acc;
    acc = 1'b0;
    a_in_valid = 1'b1; a_in_mode = m; a_in_data = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk); acc = a_in_ready;
      @(posedge clk); #1;
      if (bp_a) a_out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) chk("send_a_timeout", 64'd0, 64'd1);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic m, input logic [32:0] d);
    bit acc;
    acc = 1'b0;
    b_in_valid = 1'b1; b_in_mode = m; b_in_data = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk); acc = b_in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_b_timeout", 64'd0, 64'd1);
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input int u);
    for (int t = 0; t < 500 && sbq[u].size() != 0; t++) @(posedge clk);
    #1;
    chk($sformatf("drain%0d", u), 64'(sbq[u].size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int nv, nd;
    bit last_enc;
    rst_n = 1'b0;
    a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1; a_clr = 0;
    b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1; b_clr = 0;
    bp_a = 0; cyc = 0; n_chk = 0; n_pass = 0;
    lat_en[0] = 1; lat_en[1] = 1; cap_en[0] = 0; cap_en[1] = 0;
    #1;
    chk("reset_out_valid", 64'(a_out_valid), 64'd0);
    chk("reset_out_data", 64'(a_out_data), 64'd0);
    chk("reset_out_mode", 64'(a_out_mode), 64'd0);
    chk("reset_count", 64'(a_cnt), 64'd0);
    chk("reset_in_ready", 64'(a_in_ready), 64'd1);
    // Hand-computed values pinning the reference model.
    chk("model_enc_2aa", m_enc(64'h2AA, 10), 64'h3FF);
    chk("model_enc_3ff", m_enc(64'h3FF, 10), 64'h200);
    chk("model_dec_3ff", m_dec(64'h3FF, 10), 64'h2AA);
    chk("model_dec_200", m_dec(64'h200, 10), 64'h3FF);
    chk("model_dec_000", m_dec(64'h000, 10), 64'h000);
    chk("model_enc_w33", m_enc(64'h1_0000_0000, 33), 64'h1_8000_0000);
    chk("model_dec_w33", m_dec(64'h1_FFFF_FFFF, 33), 64'h1_5555_5555);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors, back to back with mixed modes.
    send_a(0, 10'h2AA); send_a(0, 10'h3FF);
    send_a(1, 10'h3FF); send_a(1, 10'h200); send_a(1, 10'h000);
    drain(0);
    send_b(0, 33'h1_0000_0000); send_b(1, 33'h1_FFFF_FFFF);
    drain(1);

    // Streaming round trip over every 10-bit value.
    a_clr = 1; @(posedge clk); #1; a_clr = 0;
    cap_en[0] = 1; nv = 0; nd = 0; last_enc = 0;
    while (nv < 1024 || nd < 1024) begin
      if (nv < 1024 && (cap_e[0].size() == 0 || !last_enc)) begin
        orig[0].push_back(64'(nv));
        send_a(0, 10'(nv)); nv++; last_enc = 1;
      end else if (cap_e[0].size() > 0) begin
        send_a(1, 10'(cap_e[0].pop_front())); nd++; last_enc = 0;
      end else begin
        @(posedge clk); #1;
      end
    end
    drain(0);
    cap_en[0] = 0;
    chk("xfer_count_2048", 64'(a_cnt), 64'd2048);

    // Random backpressure with in_valid held high.
    lat_en[0] = 0; bp_a = 1;
    for (int i = 0; i < 200; i++) send_a(1'($urandom_range(0, 1)), 10'($urandom));
    bp_a = 0; a_out_ready = 1;
    drain(0);
    lat_en[0] = 1;

    // Reset with two words in flight.
    send_a(0, 10'h155); send_a(1, 10'h0F0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(a_out_valid), 64'd0);
    chk("midreset_count", 64'(a_cnt), 64'd0);
    chk("midreset_out_data", 64'(a_out_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_idle", 64'(a_out_valid), 64'd0);

    // Wide round trip on B; its 4-bit counter saturates.
    cap_en[1] = 1;
    for (int i = 0; i < 12; i++) begin
      v = {32'($urandom), 32'($urandom)} & msk(33);
      orig[1].push_back(v);
      send_b(0, 33'(v));
      for (int t = 0; t < 50 && cap_e[1].size() == 0; t++) begin
        @(posedge clk); #1;
      end
      if (cap_e[1].size() == 0) chk("b_capture_timeout", 64'd0, 64'd1);
      else send_b(1, 33'(cap_e[1].pop_front()));
    end
    drain(1);
    cap_en[1] = 0;
    chk("b_saturated", 64'(b_cnt), 64'd15);

    // Clear coinciding with an output transfer.
    send_b(0, 33'h5);
    repeat (3) @(posedge clk);
    #1;
    chk("b_out_valid_before_clr", 64'(b_out_valid), 64'd1);
    b_clr = 1;
    @(posedge clk); #1;
    b_clr = 0;
    chk("clr_with_xfer", 64'(b_cnt), 64'd0);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
